// File: rtl/muldiv_unit_if.sv
// Operand/result bundle between the issue side and the HI/LO multiply/divide unit.
interface muldiv_unit_if #(
   parameter int unsigned WIDTH = 32
) ();
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             hi_we;
   logic             lo_we;
   logic [WIDTH-1:0] wdata;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, a, b, hi_we, lo_we, wdata,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, a, b, hi_we, lo_we, wdata,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit (MULTU/MULT/DIVU/DIV), one bit per clock.
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiply, divide unchanged.
module muldiv_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic          clk,
   input  logic          reset,
   muldiv_unit_if.slave  bus
);
   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
   localparam int unsigned PW    = 2 * WIDTH;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             is_div_q, is_div_d;
   logic             neg_p_q, neg_p_d;
   logic             neg_r_q, neg_r_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [PW-1:0]    p_q, p_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   msum;
   logic [PW-1:0]    mul_next;
   logic [WIDTH:0]   dcand, ddiff;
   logic             dge;
   logic [PW-1:0]    div_next;
   logic [PW-1:0]    prod_fix;
   logic [WIDTH-1:0] quot_fix, rem_fix;
`ifdef MULDIV_FAST_MUL_EN
   logic [PW-1:0]    fast_prod;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         is_div_q <= 1'b0;
         neg_p_q  <= 1'b0;
         neg_r_q  <= 1'b0;
         dvs_q    <= '0;
         a_q      <= '0;
         p_q      <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         is_div_q <= is_div_d;
         neg_p_q  <= neg_p_d;
         neg_r_q  <= neg_r_d;
         dvs_q    <= dvs_d;
         a_q      <= a_d;
         p_q      <= p_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   // Operand magnitudes and the per-iteration shift-add / restoring-subtract steps
   always_comb begin
      a_neg    = bus.op[0] & bus.a[WIDTH-1];
      b_neg    = bus.op[0] & bus.b[WIDTH-1];
      a_mag    = a_neg ? (~bus.a + WIDTH'(1)) : bus.a;
      b_mag    = b_neg ? (~bus.b + WIDTH'(1)) : bus.b;

      msum     = {1'b0, p_q[PW-1:WIDTH]} + (p_q[0] ? {1'b0, dvs_q} : '0);
      mul_next = {msum, p_q[WIDTH-1:1]};

      dcand    = p_q[PW-1:WIDTH-1];
      ddiff    = dcand - {1'b0, dvs_q};
      dge      = ~ddiff[WIDTH];
      div_next = {(dge ? ddiff[WIDTH-1:0] : dcand[WIDTH-1:0]), p_q[WIDTH-2:0], dge};

      prod_fix = neg_p_q ? (~p_q + PW'(1)) : p_q;
      quot_fix = neg_p_q ? (~p_q[WIDTH-1:0] + WIDTH'(1)) : p_q[WIDTH-1:0];
      rem_fix  = neg_r_q ? (~p_q[PW-1:WIDTH] + WIDTH'(1)) : p_q[PW-1:WIDTH];
`ifdef MULDIV_FAST_MUL_EN
      fast_prod = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
`endif
   end

   // Sequencing: IDLE accepts start or MTHI/MTLO, CALC iterates, FIX commits HI/LO
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      is_div_d = is_div_q;
      neg_p_d  = neg_p_q;
      neg_r_d  = neg_r_q;
      dvs_d    = dvs_q;
      a_d      = a_q;
      p_d      = p_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               cnt_d    = '0;
               is_div_d = bus.op[1];
               neg_p_d  = a_neg ^ b_neg;
               neg_r_d  = bus.op[1] & a_neg;
               dvs_d    = b_mag;
               a_d      = bus.a;
               p_d      = {{WIDTH{1'b0}}, a_mag};
               state_d  = S_CALC;
`ifdef MULDIV_FAST_MUL_EN
               if (!bus.op[1]) begin
                  p_d     = fast_prod;
                  state_d = S_FIX;
               end
`endif
            end else begin
               if (bus.hi_we) hi_d = bus.wdata;
               if (bus.lo_we) lo_d = bus.wdata;
            end
         end
         S_CALC: begin
            p_d   = is_div_q ? div_next : mul_next;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
         end
         S_FIX: begin
            if (!is_div_q) begin
               hi_d = prod_fix[PW-1:WIDTH];
               lo_d = prod_fix[WIDTH-1:0];
            end else if (dvs_q == '0) begin
               hi_d = a_q;
               lo_d = '1;
            end else begin
               hi_d = rem_fix;
               lo_d = quot_fix;
            end
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;
endmodule
